// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter onto one memory port.
// One whole transaction per grant, with a slave-stall timeout that returns an error response.
module mem_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                RR_EN    = 1,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_ren,
   input  logic [ADDR_W-1:0] ifu_raddr,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_rvalid,
   input  logic              lsu_ren,
   input  logic [ADDR_W-1:0] lsu_raddr,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_rvalid,
   input  logic              lsu_wen,
   input  logic [ADDR_W-1:0] lsu_waddr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [2:0]        lsu_wlen,
   output logic              lsu_wready,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_wlen,
   input  logic              mem_wready,
   output logic              busy,
   output logic              timeout_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, G_IFU, G_LSU} state_t;

   state_t        state;
   logic          op_wr;    // LSU grant is servicing a write
   logic          rr_last;  // 0 = IFU owned last, 1 = LSU owned last
   logic [CW-1:0] cnt;

   logic own_ifu, own_lsu, own_rd, own_req, own_rsp, expired, done;
   logic lsu_req, grant_lsu;

   assign own_ifu = (state == G_IFU);
   assign own_lsu = (state == G_LSU);
   assign own_rd  = own_ifu | (own_lsu & ~op_wr);
   assign own_req = own_ifu ? ifu_ren : (own_lsu ? (op_wr ? lsu_wen : lsu_ren) : 1'b0);
   // Only the response matching the owner's operation type counts.
   assign own_rsp = own_req & ((own_lsu & op_wr) ? mem_wready : mem_rvalid);
   assign expired = own_req & (cnt == TMAX);
   assign done    = own_rsp | expired;

   assign lsu_req   = lsu_ren | lsu_wen;
   assign grant_lsu = lsu_req & (~ifu_ren | (RR_EN == 0) | ~rr_last);

   assign mem_ren   = own_req & own_rd & ~expired;
   assign mem_raddr = mem_ren ? (own_ifu ? ifu_raddr : lsu_raddr) : '0;
   assign mem_wen   = own_req & own_lsu & op_wr & ~expired;
   assign mem_waddr = mem_wen ? lsu_waddr : '0;
   assign mem_wdata = mem_wen ? lsu_wdata : '0;
   assign mem_wlen  = mem_wen ? lsu_wlen  : '0;

   assign ifu_rvalid  = own_ifu & done;
   assign ifu_rdata   = own_ifu ? ((expired & ~own_rsp) ? ERR_DATA : mem_rdata) : '0;
   assign lsu_rvalid  = own_lsu & ~op_wr & done;
   assign lsu_rdata   = (own_lsu & ~op_wr) ? ((expired & ~own_rsp) ? ERR_DATA : mem_rdata) : '0;
   assign lsu_wready  = own_lsu & op_wr & done;
   assign busy        = (state != IDLE);
   assign timeout_err = expired & ~own_rsp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_wr   <= 1'b0;
         rr_last <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_lsu) begin
                  state <= G_LSU;
                  op_wr <= lsu_wen;
               end else if (ifu_ren) begin
                  state <= G_IFU;
               end
            end
            G_IFU, G_LSU: begin
               if (!own_req) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (done) begin
                  state   <= IDLE;
                  rr_last <= own_lsu;
                  cnt     <= '0;
               end else if (cnt != TMAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
